// File: rtl/board_serializer.sv
// board_serializer: walks a latched nonogram board and emits fixed-format
// {flag, index, value} messages LSB-byte-first over a valid/ready byte port.
// Sequence: START{rows}, START{cols}, CELL messages (all, or filled only),
// then END{number of CELL messages}. Abort cuts the stream short after the
// message in flight.
module board_serializer #(
    parameter int                MAX_ROWS   = 11,
    parameter int                MAX_COLS   = 11,
    parameter int                FLAG_W     = 3,
    parameter int                INDEX_W    = 12,
    parameter logic [FLAG_W-1:0] START_FLAG = 3'b111,
    parameter logic [FLAG_W-1:0] CELL_FLAG  = 3'b101,
    parameter logic [FLAG_W-1:0] END_FLAG   = 3'b000
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           valid_in,
    input  logic                           sparse,
    input  logic                           abort,
    input  logic [MAX_ROWS*MAX_COLS-1:0]   solution,
    input  logic [$clog2(MAX_ROWS)-1:0]    m,
    input  logic [$clog2(MAX_COLS)-1:0]    n,
    output logic [7:0]                     byte_out,
    output logic                           byte_valid,
    input  logic                           byte_ready,
    output logic                           busy,
    output logic                           done
);

    localparam int MSG_W = FLAG_W + INDEX_W + 1;
    localparam int NB    = (MSG_W + 7) / 8;
    localparam int SW    = NB * 8;
    localparam int BW    = (NB > 1) ? $clog2(NB) : 1;
    localparam int RW    = $clog2(MAX_ROWS + 1);
    localparam int CW    = $clog2(MAX_COLS + 1);
    localparam int CELLS = MAX_ROWS * MAX_COLS;
    localparam int PW    = (CELLS > 1) ? $clog2(CELLS) : 1;

    typedef enum logic [2:0] {S_IDLE, S_BUILD, S_SEND, S_NEXT, S_FIN} state_t;
    typedef enum logic [1:0] {M_HDR_M, M_HDR_N, M_CELL, M_END} msg_t;

    state_t            state_reg, state_next;
    msg_t              sel_reg, sel_next;

    logic [CELLS-1:0]  sol_reg;
    logic [RW-1:0]     m_reg;
    logic [CW-1:0]     n_reg;
    logic              sparse_reg;

    logic [RW-1:0]     row_reg;
    logic [CW-1:0]     col_reg;
    logic [PW-1:0]     row_base_reg;     // row_reg * MAX_COLS, kept incrementally
    logic [INDEX_W-1:0] idx_reg;         // row_reg * n' + col_reg
    logic [INDEX_W-1:0] k_reg;           // CELL messages built so far
    logic              scan_done_reg;
    logic              abort_latch_reg;

    logic [SW-1:0]     shift_reg;
    logic [BW-1:0]     byte_cnt_reg;

    logic [RW-1:0]     m_clamp;
    logic [CW-1:0]     n_clamp;
    logic              accept;
    logic              handshake;
    logic              last_byte;
    logic              abort_eff;
    logic              step_scan;
    logic [PW-1:0]     cell_pos;
    logic              cur_bit;
    logic [FLAG_W-1:0] msg_flag;
    logic [INDEX_W-1:0] msg_index;
    logic              msg_value;
    logic [SW-1:0]     msg_word;
    logic [SW-1:0]     shifted;

    assign accept    = (state_reg == S_IDLE) && valid_in;
    assign handshake = (state_reg == S_SEND) && byte_valid && byte_ready;
    assign last_byte = (byte_cnt_reg == BW'(NB - 1));
    assign abort_eff = abort || abort_latch_reg;
    assign cell_pos  = row_base_reg + PW'(col_reg);
    assign cur_bit   = sol_reg[cell_pos];
    assign shifted   = shift_reg >> 8;
    assign busy      = (state_reg != S_IDLE);
    assign done      = (state_reg == S_FIN);

    // Clamp requested dimensions to the board size.
    always_comb begin
        m_clamp = RW'(m);
        n_clamp = CW'(n);
        if (32'(m) > 32'(MAX_ROWS)) m_clamp = RW'(MAX_ROWS);
        if (32'(n) > 32'(MAX_COLS)) n_clamp = CW'(MAX_COLS);
    end

    // Assemble the message selected by sel_reg (used in BUILD).
    always_comb begin
        msg_flag  = END_FLAG;
        msg_index = k_reg;
        msg_value = 1'b0;
        case (sel_reg)
            M_HDR_M: begin msg_flag = START_FLAG; msg_index = INDEX_W'(m_reg); end
            M_HDR_N: begin msg_flag = START_FLAG; msg_index = INDEX_W'(n_reg); end
            M_CELL:  begin msg_flag = CELL_FLAG;  msg_index = idx_reg; msg_value = cur_bit; end
            default: begin msg_flag = END_FLAG;   msg_index = k_reg; end
        endcase
        msg_word = SW'({msg_flag, msg_index, msg_value});
    end

    // Next-state and message-selection logic.
    always_comb begin
        state_next = state_reg;
        sel_next   = sel_reg;
        step_scan  = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (valid_in) begin
                    state_next = S_BUILD;
                    sel_next   = M_HDR_M;
                end
            end
            S_BUILD: begin
                state_next = S_SEND;
                // The cell being built is consumed; point at the next candidate.
                if (sel_reg == M_CELL) step_scan = 1'b1;
            end
            S_SEND: begin
                if (handshake && last_byte) state_next = S_NEXT;
            end
            S_NEXT: begin
                case (sel_reg)
                    M_HDR_M: begin
                        sel_next   = M_HDR_N;
                        state_next = S_BUILD;
                    end
                    M_END: begin
                        state_next = S_FIN;
                    end
                    default: begin
                        if (abort_eff || scan_done_reg) begin
                            sel_next   = M_END;
                            state_next = S_BUILD;
                        end else if (sparse_reg && !cur_bit) begin
                            // Skip an empty cell, one per cycle.
                            step_scan = 1'b1;
                        end else begin
                            sel_next   = M_CELL;
                            state_next = S_BUILD;
                        end
                    end
                endcase
            end
            S_FIN: begin
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // FSM state and message selector registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= S_IDLE;
            sel_reg   <= M_HDR_M;
        end else begin
            state_reg <= state_next;
            sel_reg   <= sel_next;
        end
    end

    // Capture board and mode when a start is accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sol_reg    <= '0;
            m_reg      <= '0;
            n_reg      <= '0;
            sparse_reg <= 1'b0;
        end else if (accept) begin
            sol_reg    <= solution;
            m_reg      <= m_clamp;
            n_reg      <= n_clamp;
            sparse_reg <= sparse;
        end
    end

    // Row-major cell scan pointer and CELL message count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_reg       <= '0;
            col_reg       <= '0;
            row_base_reg  <= '0;
            idx_reg       <= '0;
            k_reg         <= '0;
            scan_done_reg <= 1'b0;
        end else if (accept) begin
            row_reg       <= '0;
            col_reg       <= '0;
            row_base_reg  <= '0;
            idx_reg       <= '0;
            k_reg         <= '0;
            scan_done_reg <= (m_clamp == '0) || (n_clamp == '0);
        end else begin
            if ((state_reg == S_BUILD) && (sel_reg == M_CELL)) k_reg <= k_reg + 1'b1;
            if (step_scan) begin
                idx_reg <= idx_reg + 1'b1;
                if (col_reg == n_reg - CW'(1)) begin
                    col_reg      <= '0;
                    row_reg      <= row_reg + 1'b1;
                    row_base_reg <= row_base_reg + PW'(MAX_COLS);
                    if (row_reg == m_reg - RW'(1)) scan_done_reg <= 1'b1;
                end else begin
                    col_reg <= col_reg + 1'b1;
                end
            end
        end
    end

    // Remember an abort seen at any point of the run until the next start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            abort_latch_reg <= 1'b0;
        end else if (accept) begin
            abort_latch_reg <= 1'b0;
        end else if (busy && abort) begin
            abort_latch_reg <= 1'b1;
        end
    end

    // Byte shifter and registered valid/ready output port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_reg    <= '0;
            byte_cnt_reg <= '0;
            byte_out     <= '0;
            byte_valid   <= 1'b0;
        end else if (state_reg == S_BUILD) begin
            shift_reg    <= msg_word;
            byte_out     <= msg_word[7:0];
            byte_valid   <= 1'b1;
            byte_cnt_reg <= '0;
        end else if (handshake) begin
            if (last_byte) begin
                byte_valid <= 1'b0;
            end else begin
                shift_reg    <= shifted;
                byte_out     <= shifted[7:0];
                byte_cnt_reg <= byte_cnt_reg + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_board_serializer.sv
// Scoreboard bench for board_serializer: a reference model pushes the
// expected byte stream, the monitor pops and compares on every accepted byte.
module tb_board_serializer;

    localparam int R = 11;
    localparam int C = 11;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           valid_in = 1'b0;
    logic           sparse = 1'b0;
    logic           abort = 1'b0;
    logic [R*C-1:0] solution = '0;
    logic [3:0]     m = '0;
    logic [3:0]     n = '0;
    logic [7:0]     byte_out;
    logic           byte_valid;
    logic           byte_ready = 1'b0;
    logic           busy;
    logic           done;

    board_serializer dut (
        .clk        (clk),
        .rst        (rst),
        .valid_in   (valid_in),
        .sparse     (sparse),
        .abort      (abort),
        .solution   (solution),
        .m          (m),
        .n          (n),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    logic [7:0]  exp_q[$];
    int          acc_count = 0;
    int          rdy_mode = 0;   // 0: always ready, 1: random stalls, 2: held low
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_byte = '0;
    logic [31:0] mon_exp;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push_msg(input logic [2:0] f, input int idx, input logic v);
        logic [15:0] w;
        w = {f, idx[11:0], v};
        exp_q.push_back(w[7:0]);
        exp_q.push_back(w[15:8]);
    endtask

    // Reference stream: headers, cells (optionally filled only, optionally
    // capped at maxc cells for abort), then END{cells sent}.
    task automatic model(input logic [R*C-1:0] sol, input int mm, input int nn,
                         input bit sp, input int maxc);
        int   mp, np, k;
        bit   stop;
        logic b;
        mp = (mm > R) ? R : mm;
        np = (nn > C) ? C : nn;
        k = 0;
        stop = 0;
        push_msg(3'b111, mp, 1'b0);
        push_msg(3'b111, np, 1'b0);
        for (int r = 0; r < mp; r++) begin
            for (int c = 0; c < np; c++) begin
                b = sol[r*C + c];
                if (!stop && (!sp || b)) begin
                    if (maxc >= 0 && k >= maxc) stop = 1;
                    else begin
                        push_msg(3'b101, r*np + c, b);
                        k++;
                    end
                end
            end
        end
        push_msg(3'b000, k, 1'b0);
    endtask

    function automatic logic [R*C-1:0] board3();
        logic [R*C-1:0] b;
        b = '0;
        b[0] = 1'b1; b[2] = 1'b1;                    // row 0: 101
        b[C+1] = 1'b1;                               // row 1: 010
        b[2*C] = 1'b1; b[2*C+1] = 1'b1; b[2*C+2] = 1'b1; // row 2: 111
        return b;
    endfunction

    function automatic logic [R*C-1:0] rand_board();
        logic [127:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom()};
        return t[R*C-1:0];
    endfunction

    // Monitor: compare accepted bytes, check hold behaviour during stalls.
    always @(negedge clk) begin
        if (!rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", byte_valid, 1);
                check("hold_byte", byte_out, prev_byte);
            end
            if (byte_valid && byte_ready) begin
                mon_exp = (exp_q.size() > 0) ? 32'(exp_q.pop_front()) : 32'h1FF;
                $display("byte %0d: %02h", acc_count, byte_out);
                check($sformatf("byte%0d", acc_count), byte_out, mon_exp);
                acc_count++;
            end
            prev_stall = byte_valid && !byte_ready;
            prev_byte  = byte_out;
        end
    end

    // byte_ready driver.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       byte_ready = 1'b1;
                1:       byte_ready = ($urandom_range(0, 2) != 0);
                default: byte_ready = 1'b0;
            endcase
        end
    end

    task automatic start_run(input logic [R*C-1:0] sol, input int mm, input int nn, input bit sp);
        @(posedge clk);
        #1;
        acc_count = 0;
        solution = sol;
        m = 4'(mm);
        n = 4'(nn);
        sparse = sp;
        valid_in = 1'b1;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        solution = rand_board();   // must not affect the latched run
        m = 4'($urandom());
        n = 4'($urandom());
        sparse = ~sp;
        @(negedge clk);
        check("busy_rise", busy, 1);
        check("bv_early", byte_valid, 0);
        @(negedge clk);
        check("bv_first", byte_valid, 1);
    endtask

    task automatic wait_done();
        int cyc;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!done && cyc < 3000);
        check("done", done, 1);
        check("q_left", exp_q.size(), 0);
        @(negedge clk);
        check("done_pulse", done, 0);
        check("idle_busy", busy, 0);
    endtask

    initial begin
        logic [R*C-1:0] b;
        int cyc;

        // Reset state
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_bv", byte_valid, 0);
        check("rst_byte", byte_out, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        @(posedge clk);
        #1 rst = 1'b1;

        // Dense 3x3
        rdy_mode = 0;
        model(board3(), 3, 3, 0, -1);
        start_run(board3(), 3, 3, 0);
        wait_done();

        // Sparse 3x3
        model(board3(), 3, 3, 1, -1);
        start_run(board3(), 3, 3, 1);
        wait_done();

        // Dense 3x3 with random stalls
        rdy_mode = 1;
        model(board3(), 3, 3, 0, -1);
        start_run(board3(), 3, 3, 0);
        wait_done();

        // Zero rows
        rdy_mode = 0;
        b = rand_board();
        model(b, 0, 5, 0, -1);
        start_run(b, 0, 5, 0);
        wait_done();

        // Sparse, all-zero board
        model('0, 4, 4, 1, -1);
        start_run('0, 4, 4, 1);
        wait_done();

        // Row count above MAX_ROWS is clamped
        rdy_mode = 1;
        b = rand_board();
        model(b, 15, 2, 0, -1);
        start_run(b, 15, 2, 0);
        wait_done();

        // Full board, sparse, with stalls
        b = rand_board();
        model(b, 11, 11, 1, -1);
        start_run(b, 11, 11, 1);
        wait_done();

        // Abort during byte 0 of CELL idx4
        rdy_mode = 0;
        model(board3(), 3, 3, 0, 5);
        start_run(board3(), 3, 3, 0);
        cyc = 0;
        while (!(acc_count == 12 && byte_valid) && cyc < 500) begin
            @(posedge clk);
            #2;
            cyc++;
        end
        check("abort_sync", acc_count, 12);
        abort = 1'b1;
        wait_done();
        abort = 1'b0;

        // Asynchronous reset during byte 1 of CELL idx0
        model(board3(), 3, 3, 0, -1);
        start_run(board3(), 3, 3, 0);
        cyc = 0;
        while (!(acc_count == 5 && byte_valid) && cyc < 500) begin
            @(posedge clk);
            #2;
            cyc++;
        end
        check("rst_sync", acc_count, 5);
        rdy_mode = 2;
        byte_ready = 1'b0;
        #1 rst = 1'b0;
        #1;
        check("arst_bv", byte_valid, 0);
        check("arst_byte", byte_out, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        rdy_mode = 0;

        // Restart after reset; start requests while busy are ignored
        model(board3(), 3, 3, 0, -1);
        start_run(board3(), 3, 3, 0);
        repeat (3) begin
            @(posedge clk);
            #1;
            valid_in = 1'b1;
            m = 4'd5;
            n = 4'd5;
            solution = '1;
            @(posedge clk);
            #1;
            valid_in = 1'b0;
        end
        wait_done();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
